// File: rtl/key_debounce8.sv
// Synchronise, debounce and edge-detect eight active-low key lines for the priority encoder.
// Define KEY_REPEAT_EN to add auto-repeat press strobes while keys stay held.
module key_debounce8 #(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_raw_n,
    input  logic       en_n,
    output logic [7:0] key_n,
    output logic       enc_sel_n,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_mask
);

    localparam int              DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]      STABLE_LAST = 4'(STABLE_TICKS - 1);

    if (TICK_DIV < 1 || STABLE_TICKS < 1 || STABLE_TICKS > 15 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("key_debounce8: parameter out of range");
    end

    logic [7:0]       sync1_q;
    logic [7:0]       sync_n_q;
    logic             en1_q;
    logic             enc_sel_n_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [3:0]       cnt_q [8];
    logic [3:0]       cnt_d [8];
    logic [7:0]       key_n_q;
    logic [7:0]       key_n_d;
    logic [7:0]       key_prev_q;
    logic [7:0]       fall;
    logic [7:0]       rise;
    logic             rpt_strobe;
    logic [7:0]       rpt_mask;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic [7:0]       press_mask_q;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        key_n_d = key_n_q;
        cnt_d   = cnt_q;
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (sync_n_q[i] == key_n_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == STABLE_LAST) begin
                    key_n_d[i] = sync_n_q[i];
                    cnt_d[i]   = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 8'hFF;
            sync_n_q    <= 8'hFF;
            en1_q       <= 1'b1;
            enc_sel_n_q <= 1'b1;
            div_q       <= '0;
            key_n_q     <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            sync1_q     <= key_raw_n;
            sync_n_q    <= sync1_q;
            en1_q       <= en_n;
            enc_sel_n_q <= en1_q;
            div_q       <= tick ? '0 : div_q + DIV_W'(1);
            key_n_q     <= key_n_d;
            cnt_q       <= cnt_d;
        end
    end

    // Edges are taken against a one-cycle-old copy so strobes trail key_n by exactly one cycle.
    assign fall = key_prev_q & ~key_n_q;
    assign rise = ~key_prev_q & key_n_q;

`ifdef KEY_REPEAT_EN
    localparam int               RPT_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_run_q;
    logic             rpt_hit_q;
    logic             fall_now;

    // Counting restarts at the tick a key falls, so repeats land REPEAT_TICKS ticks after the first strobe.
    assign fall_now = |(key_n_q & ~key_n_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_run_q <= 1'b0;
            rpt_hit_q <= 1'b0;
        end else begin
            rpt_hit_q <= 1'b0;
            if (key_n_d == 8'hFF) begin
                rpt_cnt_q <= '0;
                rpt_run_q <= 1'b0;
            end else if (fall_now) begin
                rpt_cnt_q <= '0;
                rpt_run_q <= ~enc_sel_n_q;
            end else if (tick && rpt_run_q) begin
                if (rpt_cnt_q == RPT_LAST) begin
                    rpt_cnt_q <= '0;
                    rpt_hit_q <= ~enc_sel_n_q;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                end
            end
        end
    end

    assign rpt_strobe = rpt_hit_q && (key_n_q != 8'hFF);
    assign rpt_mask   = rpt_strobe ? ~key_n_q : 8'h00;
`else
    assign rpt_strobe = 1'b0;
    assign rpt_mask   = 8'h00;
`endif

    // Gate on en1_q, the value enc_sel_n takes this edge, so strobes never overlap a disabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev_q      <= 8'hFF;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_mask_q    <= 8'h00;
        end else begin
            key_prev_q      <= key_n_q;
            press_pulse_q   <= ~en1_q & ((|fall) | rpt_strobe);
            release_pulse_q <= ~en1_q & (|rise);
            press_mask_q    <= en1_q ? 8'h00 : (fall | rpt_mask);
        end
    end

    assign key_n         = key_n_q;
    assign enc_sel_n     = enc_sel_n_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_mask    = press_mask_q;

endmodule

// File: tb/tb_key_debounce8.sv
// Scoreboard bench for key_debounce8 with TICK_DIV=4, STABLE_TICKS=3, REPEAT_TICKS=2.
module tb_key_debounce8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_raw_n;
    logic       en_n;
    logic [7:0] key_n;
    logic       enc_sel_n;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_mask;

    int checks   = 0;
    int failures = 0;

    // Expected strobe cycles: {press_pulse, release_pulse, press_mask}
    logic [9:0] exp_q[$];

    key_debounce8 #(
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .REPEAT_TICKS(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_raw_n    (key_raw_n),
        .en_n         (en_n),
        .key_n        (key_n),
        .enc_sel_n    (enc_sel_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_mask   (press_mask)
    );

    // clock / reset
    always #5 clk = ~clk;

    // monitor: pop and compare on every strobe cycle
    always @(negedge clk) begin
        logic [9:0] exp;
        if (rst_n) begin
            if (press_pulse || release_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe got press=%0b release=%0b mask=%h expected no strobe",
                             press_pulse, release_pulse, press_mask);
                end else begin
                    exp = exp_q.pop_front();
                    if ({press_pulse, release_pulse, press_mask} !== exp) begin
                        failures++;
                        $display("FAIL strobe got press=%0b release=%0b mask=%h expected press=%0b release=%0b mask=%h",
                                 press_pulse, release_pulse, press_mask, exp[9], exp[8], exp[7:0]);
                    end
                end
            end else begin
                checks++;
                if (press_mask !== 8'h00) begin
                    failures++;
                    $display("FAIL idle_mask got %h expected 00", press_mask);
                end
            end
        end
    end

    // driver / check tasks
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_key(input logic [7:0] v, input int maxc, output int n);
        n = 0;
        while (key_n !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_n !== v) begin
            failures++;
            $display("FAIL wait_key got %h expected %h within %0d cycles", key_n, v, maxc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        key_raw_n = 8'hFF;
        en_n      = 1'b0;

        // reset values
        cycles(2);
        chk("rst_key_n", key_n, 8'hFF);
        chk("rst_enc_sel_n", enc_sel_n, 1'b1);
        chk("rst_press", press_pulse, 1'b0);
        chk("rst_release", release_pulse, 1'b0);
        chk("rst_mask", press_mask, 8'h00);
        rst_n = 1'b1;
        cycles(1);
        chk("enc_sel_1cyc", enc_sel_n, 1'b1);
        cycles(1);
        chk("enc_sel_2cyc", enc_sel_n, 1'b0);
        cycles(100);
        chk("idle_key_n", key_n, 8'hFF);

        // clean press of key 2
        exp_q.push_back({1'b1, 1'b0, 8'h04});
        key_raw_n = 8'hFB;
        wait_key(8'hFB, 20, n);
        checks++;
        if (n < 11 || n > 14) begin
            failures++;
            $display("FAIL press_latency got %0d cycles expected 11..14", n);
        end
        chk("press_before_strobe", press_pulse, 1'b0);
        cycles(1);
        chk("press_next_cycle", press_pulse, 1'b1);
        cycles(1);
        chk("press_one_cycle", press_pulse, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);

        // bounce rejection: one 6-cycle glitch, then three 1-cycle glitches 2 cycles apart
        key_raw_n = 8'hFE;
        cycles(6);
        key_raw_n = 8'hFF;
        cycles(30);
        chk("bounce_long", key_n, 8'hFF);
        for (int g = 0; g < 3; g++) begin
            key_raw_n = 8'hFE;
            cycles(1);
            key_raw_n = 8'hFF;
            cycles(2);
        end
        cycles(30);
        chk("bounce_train", key_n, 8'hFF);

        // simultaneous events
        exp_q.push_back({1'b1, 1'b0, 8'h22});
        key_raw_n = 8'hDD;
        wait_key(8'hDD, 20, n);
        cycles(3);
        exp_q.push_back({1'b1, 1'b1, 8'h01});
        key_raw_n = 8'hFC;
        wait_key(8'hFC, 20, n);
        cycles(3);
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);

        // enable gating
        en_n = 1'b1;
        cycles(3);
        chk("gate_enc_sel_off", enc_sel_n, 1'b1);
        key_raw_n = 8'h7F;
        wait_key(8'h7F, 20, n);
        cycles(3);
        chk("gate_enc_sel_held", enc_sel_n, 1'b1);
        en_n = 1'b0;
        cycles(20);
        chk("gate_enc_sel_on", enc_sel_n, 1'b0);
        chk("gate_key_held", key_n, 8'h7F);
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);

        // reset with a key debounced low, then reset mid-qualification
        exp_q.push_back({1'b1, 1'b0, 8'h80});
        key_raw_n = 8'h7F;
        wait_key(8'h7F, 20, n);
        cycles(3);
        rst_n     = 1'b0;
        key_raw_n = 8'hFB;
        #1;
        chk("async_rst_key_n", key_n, 8'hFF);
        chk("async_rst_enc_sel", enc_sel_n, 1'b1);
        cycles(2);
        rst_n = 1'b1;
        cycles(8);
        chk("mid_key_n_before_rst", key_n, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_press", press_pulse, 1'b0);
        cycles(1);
        rst_n = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'h04});
        cycles(11);
        chk("requalify_early", key_n, 8'hFF);
        cycles(1);
        chk("requalify_flip", key_n, 8'hFB);
        cycles(1);
        chk("requalify_strobe", press_pulse, 1'b1);
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);

        // hold key 3
`ifdef KEY_REPEAT_EN
        for (int r = 0; r < 4; r++) exp_q.push_back({1'b1, 1'b0, 8'h08});
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hF7;
        wait_key(8'hF7, 20, n);
        cycles(1);
        chk("repeat_first", press_pulse, 1'b1);
        cycles(8);
        chk("repeat_8", press_pulse, 1'b1);
        cycles(8);
        chk("repeat_16", press_pulse, 1'b1);
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);
`else
        exp_q.push_back({1'b1, 1'b0, 8'h08});
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        key_raw_n = 8'hF7;
        wait_key(8'hF7, 20, n);
        cycles(30);
        chk("hold_no_repeat_key_n", key_n, 8'hF7);
        key_raw_n = 8'hFF;
        wait_key(8'hFF, 20, n);
        cycles(3);
`endif

        // final report
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes got %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
